// File: rtl/sparc_exu_div_seq.sv
// Iterative 64/32 UDIV/SDIV divider: restoring shift-subtract, one quotient bit per cycle.
// Optional condition codes (div_ccr) are enabled by defining SPARC_DIV_CC_EN.
module sparc_exu_div_seq #(
   parameter int ITER_W = 6
) (
   input  logic        clk,
   input  logic        arst_l,
   input  logic        div_req_e,
   input  logic        div_signed_e,
   input  logic [3:0]  div_thr_e,
   input  logic [31:0] yreg_mdq_y_e,
   input  logic [31:0] div_rs1_e,
   input  logic [31:0] div_rs2_e,
   input  logic        div_kill,
   input  logic        div_ack,
   output logic        div_busy,
   output logic        div_vld,
   output logic [31:0] div_result,
   output logic [3:0]  div_thr_out,
`ifdef SPARC_DIV_CC_EN
   output logic [3:0]  div_ccr,
`endif
   output logic        div_zero_trap
);

   typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;

   state_t            state_reg;
   logic              signed_reg;
   logic              neg_reg;
   logic [3:0]        thr_reg;
   logic [63:0]       dvd_reg;
   logic [31:0]       dvs_reg;
   logic [31:0]       dvs_mag_reg;
   logic [31:0]       rem_reg;
   logic [31:0]       quo_reg;
   logic [ITER_W-1:0] cnt_reg;

   logic        dvd_neg;
   logic        dvs_neg;
   logic        sign_neg;
   logic [63:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic        early_ovf;
   logic [31:0] check_sat;
   logic [32:0] shifted;
   logic [32:0] trial;
   logic        q_bit;
   logic [31:0] rem_next;
   logic [31:0] fix_val;

   always_comb begin
      dvd_neg   = signed_reg & dvd_reg[63];
      dvs_neg   = signed_reg & dvs_reg[31];
      sign_neg  = dvd_neg ^ dvs_neg;
      dvd_mag   = dvd_neg ? (~dvd_reg) + 64'd1 : dvd_reg;
      dvs_mag   = dvs_neg ? (~dvs_reg) + 32'd1 : dvs_reg;
      // Quotient cannot fit in 32 bits once the high half reaches the divisor.
      early_ovf = (dvd_mag[63:32] >= dvs_mag);
      if (!signed_reg)
         check_sat = 32'hFFFF_FFFF;
      else if (sign_neg)
         check_sat = 32'h8000_0000;
      else
         check_sat = 32'h7FFF_FFFF;
   end

   // 33-bit partial remainder: the shifted-in value may exceed 32 bits before subtraction.
   always_comb begin
      shifted  = {rem_reg, quo_reg[31]};
      trial    = shifted - {1'b0, dvs_mag_reg};
      q_bit    = ~trial[32];
      rem_next = q_bit ? trial[31:0] : shifted[31:0];
   end

   always_comb begin
      fix_val = quo_reg;
      if (signed_reg) begin
         if (!neg_reg) begin
            if (quo_reg > 32'h7FFF_FFFF)
               fix_val = 32'h7FFF_FFFF;
         end else begin
            if (quo_reg > 32'h8000_0000)
               fix_val = 32'h8000_0000;
            else
               fix_val = (~quo_reg) + 32'd1;
         end
      end
   end

`ifdef SPARC_DIV_CC_EN
   logic       fix_ovf;
   logic [3:0] cc_fix;
   logic [3:0] cc_sat;

   always_comb begin
      fix_ovf = signed_reg & (neg_reg ? (quo_reg > 32'h8000_0000) : (quo_reg > 32'h7FFF_FFFF));
      cc_fix  = {fix_val[31], (fix_val == 32'd0), fix_ovf, 1'b0};
      cc_sat  = {check_sat[31], 1'b0, 1'b1, 1'b0};
   end
`endif

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         state_reg     <= IDLE;
         signed_reg    <= 1'b0;
         neg_reg       <= 1'b0;
         thr_reg       <= 4'd0;
         dvd_reg       <= 64'd0;
         dvs_reg       <= 32'd0;
         dvs_mag_reg   <= 32'd0;
         rem_reg       <= 32'd0;
         quo_reg       <= 32'd0;
         cnt_reg       <= '0;
         div_busy      <= 1'b0;
         div_vld       <= 1'b0;
         div_result    <= 32'd0;
         div_thr_out   <= 4'd0;
         div_zero_trap <= 1'b0;
`ifdef SPARC_DIV_CC_EN
         div_ccr       <= 4'd0;
`endif
      end else if (div_kill) begin
         state_reg     <= IDLE;
         div_busy      <= 1'b0;
         div_vld       <= 1'b0;
         div_result    <= 32'd0;
         div_thr_out   <= 4'd0;
         div_zero_trap <= 1'b0;
`ifdef SPARC_DIV_CC_EN
         div_ccr       <= 4'd0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (div_req_e) begin
                  signed_reg <= div_signed_e;
                  thr_reg    <= div_thr_e;
                  dvd_reg    <= {yreg_mdq_y_e, div_rs1_e};
                  dvs_reg    <= div_rs2_e;
                  div_busy   <= 1'b1;
                  state_reg  <= CHECK;
               end
            end
            CHECK: begin
               neg_reg     <= sign_neg;
               dvs_mag_reg <= dvs_mag;
               rem_reg     <= dvd_mag[63:32];
               quo_reg     <= dvd_mag[31:0];
               if (dvs_mag == 32'd0) begin
                  div_result    <= 32'd0;
                  div_zero_trap <= 1'b1;
                  div_thr_out   <= thr_reg;
`ifdef SPARC_DIV_CC_EN
                  div_ccr       <= 4'd0;
`endif
                  state_reg     <= DONE;
               end else if (early_ovf) begin
                  div_result    <= check_sat;
                  div_zero_trap <= 1'b0;
                  div_thr_out   <= thr_reg;
`ifdef SPARC_DIV_CC_EN
                  div_ccr       <= cc_sat;
`endif
                  state_reg     <= DONE;
               end else begin
                  cnt_reg   <= ITER_W'(32);
                  state_reg <= ITER;
               end
            end
            ITER: begin
               rem_reg <= rem_next;
               quo_reg <= {quo_reg[30:0], q_bit};
               cnt_reg <= cnt_reg - ITER_W'(1);
               if (cnt_reg == ITER_W'(1))
                  state_reg <= FIX;
            end
            FIX: begin
               div_result    <= fix_val;
               div_zero_trap <= 1'b0;
               div_thr_out   <= thr_reg;
`ifdef SPARC_DIV_CC_EN
               div_ccr       <= cc_fix;
`endif
               state_reg     <= DONE;
            end
            DONE: begin
               // Result is presented one cycle after entering DONE; ack only counts once it is visible.
               if (div_ack && div_vld) begin
                  div_vld   <= 1'b0;
                  div_busy  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  div_vld <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sparc_exu_div_seq.sv
// Directed, table-driven bench for sparc_exu_div_seq plus kill/reset sequences.
module tb_sparc_exu_div_seq;

   logic        clk = 1'b0;
   logic        arst_l;
   logic        div_req_e;
   logic        div_signed_e;
   logic [3:0]  div_thr_e;
   logic [31:0] yreg_mdq_y_e;
   logic [31:0] div_rs1_e;
   logic [31:0] div_rs2_e;
   logic        div_kill;
   logic        div_ack;
   logic        div_busy;
   logic        div_vld;
   logic [31:0] div_result;
   logic [3:0]  div_thr_out;
   logic        div_zero_trap;
`ifdef SPARC_DIV_CC_EN
   logic [3:0]  div_ccr;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sparc_exu_div_seq #(.ITER_W(6)) dut (
      .clk          (clk),
      .arst_l       (arst_l),
      .div_req_e    (div_req_e),
      .div_signed_e (div_signed_e),
      .div_thr_e    (div_thr_e),
      .yreg_mdq_y_e (yreg_mdq_y_e),
      .div_rs1_e    (div_rs1_e),
      .div_rs2_e    (div_rs2_e),
      .div_kill     (div_kill),
      .div_ack      (div_ack),
      .div_busy     (div_busy),
      .div_vld      (div_vld),
      .div_result   (div_result),
      .div_thr_out  (div_thr_out),
`ifdef SPARC_DIV_CC_EN
      .div_ccr      (div_ccr),
`endif
      .div_zero_trap(div_zero_trap)
   );

   typedef struct {
      logic        sgn;
      logic [3:0]  thr;
      logic [31:0] y;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] exp_res;
      logic        exp_zero;
      int          exp_lat;
      logic [3:0]  exp_ccr;
      int          hold;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_op(input int idx);
      vec_t v;
      int   lat;
      v = vecs[idx];
      lat = 0;
      @(negedge clk);
      div_req_e    = 1'b1;
      div_signed_e = v.sgn;
      div_thr_e    = v.thr;
      yreg_mdq_y_e = v.y;
      div_rs1_e    = v.rs1;
      div_rs2_e    = v.rs2;
      @(posedge clk);
      #1;
      chk($sformatf("busy_rise[%0d]", idx), 32'(div_busy), 32'd1);
      @(negedge clk);
      div_req_e    = 1'b0;
      yreg_mdq_y_e = 32'hDEAD_BEEF;
      div_rs1_e    = 32'h1234_5678;
      div_rs2_e    = 32'h0000_0003;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (div_vld) begin
            lat = c;
            break;
         end
      end
      chk($sformatf("latency[%0d]", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("result[%0d]", idx), div_result, v.exp_res);
      chk($sformatf("thr_out[%0d]", idx), 32'(div_thr_out), 32'(v.thr));
      chk($sformatf("zero_trap[%0d]", idx), 32'(div_zero_trap), 32'(v.exp_zero));
`ifdef SPARC_DIV_CC_EN
      chk($sformatf("ccr[%0d]", idx), 32'(div_ccr), 32'(v.exp_ccr));
`endif
      $display("txn %0d sgn=%0d y=%h rs1=%h rs2=%h res=%h thr=%b zt=%0d lat=%0d",
               idx, v.sgn, v.y, v.rs1, v.rs2, div_result, div_thr_out, div_zero_trap, lat);
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold[%0d.%0d]", idx, h),
             {div_vld, div_zero_trap, div_thr_out, div_result[25:0]},
             {1'b1, v.exp_zero, v.thr, v.exp_res[25:0]});
      end
      @(negedge clk);
      div_ack = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("ack_idle[%0d]", idx), {30'd0, div_vld, div_busy}, 32'd0);
      @(negedge clk);
      div_ack = 1'b0;
   endtask

   initial begin
      logic seen_vld;
      //          sgn   thr      y              rs1            rs2            exp_res        zt    lat ccr      hold
      vecs[0]  = '{1'b0, 4'b0010, 32'h0000_0000, 32'd100,       32'd7,         32'd14,        1'b0, 35, 4'b0000, 0};
      vecs[1]  = '{1'b1, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 35, 4'b1000, 0};
      vecs[2]  = '{1'b0, 4'b0100, 32'h0000_0005, 32'h0000_0000, 32'd5,         32'hFFFF_FFFF, 1'b0, 2,  4'b1010, 0};
      vecs[3]  = '{1'b1, 4'b1000, 32'h0000_0000, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 35, 4'b0010, 0};
      vecs[4]  = '{1'b0, 4'b1000, 32'h0000_0001, 32'h0000_0002, 32'd0,         32'h0000_0000, 1'b1, 2,  4'b0000, 5};
      vecs[5]  = '{1'b1, 4'b0010, 32'h0000_0000, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 35, 4'b1000, 0};
      vecs[6]  = '{1'b1, 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0, 35, 4'b0000, 0};
      vecs[7]  = '{1'b1, 4'b0001, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2,  4'b1010, 0};
      vecs[8]  = '{1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 35, 4'b1010, 0};
      vecs[9]  = '{1'b1, 4'b0100, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 35, 4'b1000, 0};
      vecs[10] = '{1'b0, 4'b1000, 32'h0000_0003, 32'h0000_0000, 32'h10,        32'h3000_0000, 1'b0, 35, 4'b0000, 0};
      vecs[11] = '{1'b0, 4'b0001, 32'h0000_0000, 32'h0000_0000, 32'd9,         32'h0000_0000, 1'b0, 35, 4'b0100, 0};
      vecs[12] = '{1'b1, 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'h0000_0000, 1'b1, 2,  4'b0000, 0};

      arst_l       = 1'b0;
      div_req_e    = 1'b0;
      div_signed_e = 1'b0;
      div_thr_e    = 4'd0;
      yreg_mdq_y_e = 32'd0;
      div_rs1_e    = 32'd0;
      div_rs2_e    = 32'd0;
      div_kill     = 1'b0;
      div_ack      = 1'b0;
      #1;
      chk("reset_outputs", {div_result[24:0], div_thr_out, div_zero_trap, div_vld, div_busy}, 32'd0);
      repeat (2) @(negedge clk);
      arst_l = 1'b1;

      for (int i = 0; i < NVEC; i++)
         run_op(i);

      // Kill beats request in IDLE.
      @(negedge clk);
      div_req_e = 1'b1; div_signed_e = 1'b0; div_thr_e = 4'b0001;
      yreg_mdq_y_e = 32'd0; div_rs1_e = 32'd50; div_rs2_e = 32'd5;
      div_kill = 1'b1;
      @(posedge clk);
      #1;
      chk("kill_over_req", 32'(div_busy), 32'd0);
      @(negedge clk);
      div_kill = 1'b0; div_req_e = 1'b0;

      // Kill in the middle of the iteration phase, then a fresh op.
      @(negedge clk);
      div_req_e = 1'b1; div_signed_e = 1'b0; div_thr_e = 4'b0100;
      yreg_mdq_y_e = 32'd0; div_rs1_e = 32'd1000; div_rs2_e = 32'd3;
      @(posedge clk);
      @(negedge clk);
      div_req_e = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      div_kill = 1'b1;
      @(posedge clk);
      #1;
      chk("kill_idle", {30'd0, div_vld, div_busy}, 32'd0);
      @(negedge clk);
      div_kill = 1'b0;
      seen_vld = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen_vld = seen_vld | div_vld;
      end
      chk("kill_no_result", 32'(seen_vld), 32'd0);
      $display("txn kill_mid_iter vld_seen=%0d", seen_vld);
      run_op(0);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      div_req_e = 1'b1; div_signed_e = 1'b1; div_thr_e = 4'b1000;
      yreg_mdq_y_e = 32'd0; div_rs1_e = 32'd77; div_rs2_e = 32'd7;
      @(posedge clk);
      @(negedge clk);
      div_req_e = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("busy_before_reset", 32'(div_busy), 32'd1);
      #2;
      arst_l = 1'b0;
      #1;
      chk("async_reset", {div_result[24:0], div_thr_out, div_zero_trap, div_vld, div_busy}, 32'd0);
`ifdef SPARC_DIV_CC_EN
      chk("async_reset_ccr", 32'(div_ccr), 32'd0);
`endif
      $display("txn async_reset busy=%0d vld=%0d res=%h", div_busy, div_vld, div_result);
      @(negedge clk);
      arst_l = 1'b1;
      run_op(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sparc_exu_div_seq.md
Name: sparc_exu_div_seq

Overview:
- Iterative 64-by-32 integer divider for UDIV/SDIV, directly downstream of the per-thread Y register.
- Dividend is {Y, rs1}; Y arrives on yreg_mdq_y_e in the E stage alongside rs1/rs2.
- Produces a 32-bit saturated quotient, thread tag and divide-by-zero flag, one bit per cycle.
- Single outstanding operation; the remainder is discarded.

Parameters:
- ITER_W, 6, width of the iteration counter; must hold 32.

Ports:
- clk  input  1  core clock
- arst_l  input  1  asynchronous active-low reset
- div_req_e  input  1  start request; sampled only when div_busy=0
- div_signed_e  input  1  1=SDIV, 0=UDIV
- div_thr_e  input  4  one-hot thread id of the request
- yreg_mdq_y_e  input  32  Y value: dividend upper half
- div_rs1_e  input  32  dividend lower half
- div_rs2_e  input  32  divisor
- div_kill  input  1  abort current operation (trap/flush)
- div_ack  input  1  consumer accepts result
- div_busy  output  1  operation in flight or result pending
- div_vld  output  1  result valid; held until acked
- div_result  output  32  quotient
- div_thr_out  output  4  thread tag of result
- div_zero_trap  output  1  divisor was zero; qualifies div_vld

Behaviour:
- Reset (async, arst_l=0): state IDLE; div_busy=0, div_vld=0, div_result=0, div_thr_out=0, div_zero_trap=0; all internal registers cleared.
- FSM states: IDLE, CHECK, ITER, FIX, DONE.
- IDLE:
  - If div_req_e=1 and div_kill=0: capture operands, signed flag and thread; go to CHECK.
  - div_busy rises the cycle after capture.
- CHECK:
  - Signed: form 64-bit |dividend| and 32-bit |divisor|; record result sign = dividend[63] XOR divisor[31].
  - Divisor==0: result=0, div_zero_trap=1, go to DONE.
  - Else if magnitude high half >= |divisor|: overflow; saturate and go to DONE.
    - Unsigned saturation: 0xFFFFFFFF.
    - Signed saturation: 0x7FFFFFFF if sign positive, 0x80000000 if negative.
  - Else: load counter=32, go to ITER.
- ITER:
  - Restoring shift-subtract on a 33-bit partial remainder; one quotient bit per cycle, MSB first.
  - Counter decrements each cycle; go to FIX when it reaches 0. ITER lasts exactly 32 cycles.
- FIX:
  - Unsigned: result = magnitude.
  - Signed positive: if magnitude > 0x7FFFFFFF, result = 0x7FFFFFFF.
  - Signed negative: if magnitude > 0x80000000, result = 0x80000000; otherwise result = two's complement of magnitude.
  - Go to DONE.
- DONE:
  - div_vld=1; div_result, div_thr_out and div_zero_trap stable.
  - On div_ack: go to IDLE and clear div_vld the next cycle.
- Latency (request sampled at edge 0):
  - Normal: div_vld at cycle 35.
  - Zero divisor or early overflow: div_vld at cycle 2.
- A new request is accepted no earlier than the cycle after div_vld drops; div_req_e while busy is ignored (the issuer must hold the thread switched out).
- div_kill in any state: return to IDLE next cycle, div_vld=0, div_zero_trap=0, no result.
  - Kill has priority over req in IDLE and over ack in DONE.
- div_ack outside DONE is ignored.
- Operands are not re-sampled after capture; later changes to yreg_mdq_y_e have no effect.

Optional Feature:
- Macro: SPARC_DIV_CC_EN.
- When defined:
  - Adds output div_ccr[3:0] = {N,Z,V,C} for UDIVcc/SDIVcc, valid with div_vld.
  - N = result[31]; Z = (result==0); V = 1 on overflow saturation; C = 0.
  - Reset value is 0; div_ccr=0 on a zero-divide trap.
- When undefined: port absent, no CC logic.

Test Plan:
- UDIV Y=0, rs1=100, rs2=7, thr=0010 -> div_vld at cycle 35, result=14, thr_out=0010, zero_trap=0.
- SDIV Y=0xFFFFFFFF, rs1=0xFFFFFF9C (-100), rs2=7 -> result=0xFFFFFFF2 (-14) at cycle 35; with CC_EN, ccr=1000.
- UDIV Y=5, rs1=0, rs2=5 -> overflow; result=0xFFFFFFFF at cycle 2; with CC_EN, V=1.
- SDIV Y=0, rs1=0x80000000, rs2=1 -> result=0x7FFFFFFF (late saturation in FIX) at cycle 35.
- Any rs2=0 -> div_vld at cycle 2, zero_trap=1, result=0; hold ack low 5 cycles -> outputs stable; ack -> idle.
- Assert div_kill at cycle 10 of ITER, then new request -> no div_vld for the first; second completes correctly. Assert arst_l low mid-ITER -> all outputs 0 immediately.
